// File: rtl/mpsoc_shared_slave_arbiter.sv
// ---------------------------------------------------------------------------
// mpsoc_shared_slave_arbiter
//
// Round-robin arbiter that shares a single Avalon-MM slave between
// NUM_MASTERS CPU data masters. One transfer is in flight at a time. Losing
// masters are held in waitrequest. Each completed transfer is signalled by
// dropping that master's waitrequest for exactly one cycle. Read data is
// captured into a register and broadcast to all masters.
//
// Ports
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   m_address      packed master word addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_read         per-master read request
//   m_write        per-master write request (ignored when m_read is also set)
//   m_writedata    packed master write data, master i at [i*DATA_W +: DATA_W]
//   m_readdata     last captured read data, shared by all masters
//   m_waitrequest  per-master stall; low for one cycle when the transfer ends
//   s_address      slave address
//   s_read         slave read strobe
//   s_write        slave write strobe
//   s_writedata    slave write data
//   s_readdata     slave read data
//   s_waitrequest  slave stall
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no transfer; pick the next requester starting at rr_ptr
// ST_ISSUE | drive s_read or s_write from the latched request until accepted
// ST_WAIT  | read accepted; count down the slave read latency
// ST_DONE  | one-cycle completion strobe to the granted master
// ---------------------------------------------------------------------------
module mpsoc_shared_slave_arbiter #(
    parameter int NUM_MASTERS  = 2,
    parameter int ADDR_W       = 1,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [ADDR_W-1:0]             s_address,
    output logic                          s_read,
    output logic                          s_write,
    output logic [DATA_W-1:0]             s_writedata,
    input  logic [DATA_W-1:0]             s_readdata,
    input  logic                          s_waitrequest
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int LAT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     gnt_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic                 is_read_q;
    logic [LAT_W-1:0]     lat_cnt_q;
    logic [DATA_W-1:0]    rdata_q;

    logic [NUM_MASTERS-1:0] req;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_is_read;

    logic                 do_grant;
    logic                 do_capture;
    logic                 do_load_cnt;
    int                   cand;

    // A simultaneous read and write counts as a read; the write is dropped.
    assign req = m_read | m_write;

    // Scan from rr_ptr upward, wrapping, and take the first requester found.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!sel_found && req[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    // Request mux for the selected master.
    always_comb begin
        sel_addr    = '0;
        sel_wdata   = '0;
        sel_is_read = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (IDX_W'(k) == sel_idx) begin
                sel_addr    = m_address[k*ADDR_W +: ADDR_W];
                sel_wdata   = m_writedata[k*DATA_W +: DATA_W];
                sel_is_read = m_read[k];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        do_grant    = 1'b0;
        do_capture  = 1'b0;
        do_load_cnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    do_grant = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!s_waitrequest) begin
                    if (!is_read_q) begin
                        state_d = ST_DONE;
                    end else if (READ_LATENCY == 0) begin
                        do_capture = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        do_load_cnt = 1'b1;
                        state_d     = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // The slave's data is valid on the last counted cycle.
                if (lat_cnt_q == LAT_W'(1)) begin
                    do_capture = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_read_q <= 1'b0;
            lat_cnt_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (do_grant) begin
                gnt_q     <= sel_idx;
                addr_q    <= sel_addr;
                wdata_q   <= sel_wdata;
                is_read_q <= sel_is_read;
            end
            if (do_load_cnt) begin
                lat_cnt_q <= LAT_W'(READ_LATENCY);
            end else if (state_q == ST_WAIT) begin
                lat_cnt_q <= lat_cnt_q - LAT_W'(1);
            end
            if (do_capture) begin
                rdata_q <= s_readdata;
            end
            // Pointer moves past the master just served, so it goes last next round.
            if (state_q == ST_DONE) begin
                if (gnt_q == IDX_W'(NUM_MASTERS - 1)) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= gnt_q + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        m_waitrequest = '1;
        if (state_q == ST_DONE) begin
            m_waitrequest[gnt_q] = 1'b0;
        end
    end

    assign s_address   = addr_q;
    assign s_writedata = wdata_q;
    assign s_read      = (state_q == ST_ISSUE) &&  is_read_q;
    assign s_write     = (state_q == ST_ISSUE) && !is_read_q;
    assign m_readdata  = rdata_q;

endmodule
